// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline blocks.
//   RESET_PC_DEF     default reset PC and base of the instruction space
//   IM_ADDRBITS_DEF  default instruction-memory word-index width
//   NOP              instruction word used for squashed or faulted slots
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_3000;
  localparam int unsigned IM_ADDRBITS_DEF = 12;
  localparam logic [31:0] NOP             = 32'h0000_0000;

endpackage

// File: rtl/pc_range_check.sv
// Combinational address legality check. It is shared by the fetch path and the
// data-memory address path.
// Ports:
//   addr   in   32  byte address under test
//   legal  out  1   word-aligned and inside [BASE, BASE + 4*2^ADDRBITS)
module pc_range_check
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE     = RESET_PC_DEF,
  parameter int unsigned ADDRBITS = IM_ADDRBITS_DEF
) (
  input  logic [31:0] addr,
  output logic        legal
);

  // The arithmetic is 33 bits wide so that the upper bound cannot wrap.
  logic [32:0] lo_bound;
  logic [32:0] hi_bound;
  logic [32:0] addr_ext;

  always_comb begin
    lo_bound = {1'b0, BASE};
    hi_bound = lo_bound + (33'd4 << ADDRBITS);
    addr_ext = {1'b0, addr};
    legal    = (addr[1:0] == 2'b00) && (addr_ext >= lo_bound) && (addr_ext < hi_bound);
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. It owns the PC, drives the combinational
// instruction-memory port and loads the IF/ID latch. Branch redirects are taken
// with one delay slot.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   stall               holds the PC and IF/ID; any redirect is ignored
//   redirect_valid/pc   taken branch or jump target from ID
//   im_addr, im_rdata   instruction-memory address out and word back, same cycle
//   pc_f                current PC
//   if_id_*             latched instr, pc, pc+8, valid and fault flags
//   fault_sticky        set by the first illegal fetch, cleared only by reset
//   fetch_cnt           saturating count of valid instructions latched
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int unsigned IM_ADDRBITS = IM_ADDRBITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic        if_id_valid,
  output logic        if_id_fault,
  output logic        fault_sticky,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc8_q, ifpc8_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        sticky_q, sticky_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        pc_legal;

  pc_range_check #(
    .BASE     (RESET_PC),
    .ADDRBITS (IM_ADDRBITS)
  ) u_range (
    .addr  (pc_q),
    .legal (pc_legal)
  );

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    ifpc_d      = ifpc_q;
    ifpc8_d     = ifpc8_q;
    valid_d     = valid_q;
    fault_d     = fault_q;
    sticky_d    = sticky_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!stall) begin
      // The word fetched this cycle is latched even when a redirect is seen
      // (delay slot). The target is fetched on the next cycle.
      pc_d    = redirect_valid ? redirect_pc : pc_q + 32'd4;
      ifpc_d  = pc_q;
      ifpc8_d = pc_q + 32'd8;
      if (pc_legal) begin
        instr_d = im_rdata;
        valid_d = 1'b1;
        fault_d = 1'b0;
        if (fetch_cnt_q != 32'hFFFF_FFFF) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end else begin
        instr_d  = NOP;
        valid_d  = 1'b0;
        fault_d  = 1'b1;
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP;
      ifpc_q      <= RESET_PC;
      ifpc8_q     <= RESET_PC + 32'd8;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      sticky_q    <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ifpc_q      <= ifpc_d;
      ifpc8_q     <= ifpc8_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
      sticky_q    <= sticky_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign im_addr      = pc_q;
  assign pc_f         = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc     = ifpc_q;
  assign if_id_pc8    = ifpc8_q;
  assign if_id_valid  = valid_q;
  assign if_id_fault  = fault_q;
  assign fault_sticky = sticky_q;
  assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit. The driver applies one directed vector
// per cycle and queues the state expected after that edge. The monitor pops
// and compares the queued state 1 ns after each rising edge.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr, im_rdata, pc_f;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc8, fetch_cnt;
  logic        if_id_valid, if_id_fault, fault_sticky;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc8;
    logic        v;
    logic        f;
    logic        st;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   step_no     = 0;

  always #5 clk = ~clk;

  // Instruction memory model: each word is its own address with A5A5 in the top half.
  always_comb im_rdata = im_addr ^ 32'hA5A5_0000;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .pc_f           (pc_f),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc8      (if_id_pc8),
    .if_id_valid    (if_id_valid),
    .if_id_fault    (if_id_fault),
    .fault_sticky   (fault_sticky),
    .fetch_cnt      (fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, req);
    end
  endtask

  // Monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_no++;
      chk("im_addr", im_addr, e.pc);
      chk("pc_f", pc_f, e.pc);
      chk("if_id_instr", if_id_instr, e.instr);
      chk("if_id_pc", if_id_pc, e.ipc);
      chk("if_id_pc8", if_id_pc8, e.ipc8);
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.v});
      chk("if_id_fault", {31'd0, if_id_fault}, {31'd0, e.f});
      chk("fault_sticky", {31'd0, fault_sticky}, {31'd0, e.st});
      chk("fetch_cnt", fetch_cnt, e.cnt);
    end
  end

  // frc: 1 forces the counter to all ones, 2 releases it.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] ipc, input logic [31:0] ipc8,
                      input logic v, input logic f, input logic st,
                      input logic [31:0] cnt, input int frc);
    exp_t e;
    @(negedge clk);
    if (frc == 1) force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    if (frc == 2) release dut.fetch_cnt_q;
    reset          = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    e.pc = pc; e.instr = instr; e.ipc = ipc; e.ipc8 = ipc8;
    e.v = v; e.f = f; e.st = st; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  localparam logic [31:0] P = 32'hA5A5_0000;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    //   r  s  rv  rpc          pc      instr        ipc     ipc8  v  f  st cnt
    step(1, 0, 0, 0,            'h3000, 0,           'h3000, 'h3008, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0,            'h3004, P|'h3000,    'h3000, 'h3008, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0,            'h3008, P|'h3004,    'h3004, 'h300C, 1, 0, 0, 2, 0);
    step(0, 0, 0, 0,            'h300C, P|'h3008,    'h3008, 'h3010, 1, 0, 0, 3, 0);
    step(0, 0, 0, 0,            'h3010, P|'h300C,    'h300C, 'h3014, 1, 0, 0, 4, 0);
    // Redirect at 0x3010: the delay slot is latched, then the target is fetched.
    step(0, 0, 1, 'h3100,       'h3100, P|'h3010,    'h3010, 'h3018, 1, 0, 0, 5, 0);
    step(0, 0, 0, 0,            'h3104, P|'h3100,    'h3100, 'h3108, 1, 0, 0, 6, 0);
    step(0, 0, 1, 'h3020,       'h3020, P|'h3104,    'h3104, 'h310C, 1, 0, 0, 7, 0);
    // Stalled with a redirect pending: everything holds.
    step(0, 1, 1, 'h3200,       'h3020, P|'h3104,    'h3104, 'h310C, 1, 0, 0, 7, 0);
    step(0, 1, 1, 'h3200,       'h3020, P|'h3104,    'h3104, 'h310C, 1, 0, 0, 7, 0);
    step(0, 1, 1, 'h3200,       'h3020, P|'h3104,    'h3104, 'h310C, 1, 0, 0, 7, 0);
    step(0, 0, 1, 'h3200,       'h3200, P|'h3020,    'h3020, 'h3028, 1, 0, 0, 8, 0);
    // Misaligned target.
    step(0, 0, 1, 'h3002,       'h3002, P|'h3200,    'h3200, 'h3208, 1, 0, 0, 9, 0);
    step(0, 0, 0, 0,            'h3006, 0,           'h3002, 'h300A, 0, 1, 1, 9, 0);
    step(0, 0, 1, 'h3040,       'h3040, 0,           'h3006, 'h300E, 0, 1, 1, 9, 0);
    step(0, 0, 0, 0,            'h3044, P|'h3040,    'h3040, 'h3048, 1, 0, 1, 10, 0);
    // Reset, then target at the upper limit.
    step(1, 0, 0, 0,            'h3000, 0,           'h3000, 'h3008, 0, 0, 0, 0, 0);
    step(0, 0, 1, 'h7000,       'h7000, P|'h3000,    'h3000, 'h3008, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0,            'h7004, 0,           'h7000, 'h7008, 0, 1, 1, 1, 0);
    // Last legal word, then run off the end.
    step(0, 0, 1, 'h6FFC,       'h6FFC, 0,           'h7004, 'h700C, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0,            'h7000, P|'h6FFC,    'h6FFC, 'h7004, 1, 0, 1, 2, 0);
    step(0, 0, 0, 0,            'h7004, 0,           'h7000, 'h7008, 0, 1, 1, 2, 0);
    // Just below the base.
    step(0, 0, 1, 'h2FFC,       'h2FFC, 0,           'h7004, 'h700C, 0, 1, 1, 2, 0);
    step(0, 0, 0, 0,            'h3000, 0,           'h2FFC, 'h3004, 0, 1, 1, 2, 0);
    step(0, 0, 0, 0,            'h3004, P|'h3000,    'h3000, 'h3008, 1, 0, 1, 3, 0);
    // Reset wins over stall and redirect.
    step(0, 1, 1, 'h3200,       'h3004, P|'h3000,    'h3000, 'h3008, 1, 0, 1, 3, 0);
    step(1, 1, 1, 'h3200,       'h3000, 0,           'h3000, 'h3008, 0, 0, 0, 0, 0);
    // Saturation: hold the counter at all ones across one edge, then release it.
    step(0, 0, 0, 0,            'h3004, P|'h3000,    'h3000, 'h3008, 1, 0, 0, 'hFFFF_FFFF, 1);
    step(0, 0, 0, 0,            'h3008, P|'h3004,    'h3004, 'h300C, 1, 0, 0, 'hFFFF_FFFF, 2);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the 5-stage MIPS pipeline.
- Owns the PC register and drives the combinational instruction-memory read port: address out, word back in the same cycle.
- Registers the fetched word into the IF/ID pipeline latch.
- Honours hazard-unit stalls and ID-stage branch/jump redirects with single-delay-slot semantics; flags illegal fetch addresses.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; base of the instruction space.
- IM_ADDRBITS, 12, word-index width of the instruction memory; legal span is 4*2^IM_ADDRBITS bytes starting at RESET_PC.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; holds PC and IF/ID
- redirect_valid  in  1  ID stage resolved a taken branch/j/jal/jr this cycle
- redirect_pc  in  32  target PC for redirect_valid
- im_addr  out  32  byte address to instruction memory (= current PC, combinational)
- im_rdata  in  32  instruction word returned combinationally
- pc_f  out  32  current PC (debug/exception use)
- if_id_instr  out  32  latched instruction
- if_id_pc  out  32  PC of the latched instruction
- if_id_pc8  out  32  if_id_pc + 8 (jal/jalr link value)
- if_id_valid  out  1  latched slot holds a real fetched instruction
- if_id_fault  out  1  latched slot came from an illegal PC
- fault_sticky  out  1  set on first illegal fetch, cleared only by reset
- fetch_cnt  out  32  count of valid instructions latched into IF/ID, saturating

Behaviour:
- Reset (clk edge with reset=1): pc=RESET_PC; if_id_instr=0; if_id_pc=RESET_PC; if_id_pc8=RESET_PC+8; if_id_valid=0; if_id_fault=0; fault_sticky=0; fetch_cnt=0. Reset overrides every other input, including mid-stall or mid-redirect.
- im_addr = pc_f = pc, purely combinational. No memory request handshake: im_rdata is valid in the same cycle.
- Illegal PC (combinational): pc[1:0]!=0, OR pc < RESET_PC, OR pc >= RESET_PC + (4<<IM_ADDRBITS). Compare in 33-bit unsigned arithmetic so the upper-bound sum cannot wrap.
- Normal edge (reset=0, stall=0):
  - pc <= redirect_valid ? redirect_pc : pc+4. The +4 is 32-bit and wraps silently; the wrapped value is then illegal.
  - IF/ID loads if_id_pc=pc and if_id_pc8=pc+8.
  - If legal: if_id_instr=im_rdata, if_id_valid=1, if_id_fault=0.
  - If illegal: if_id_instr=0 (nop), if_id_valid=0, if_id_fault=1, fault_sticky<=1.
- Delay slot: a redirect never clears IF/ID. The instruction fetched in the same cycle the redirect is seen is the delay slot and is latched normally. Target fetch starts the next cycle, so redirect-to-target latency is 1 cycle.
- Stall edge (reset=0, stall=1): pc and all IF/ID registers hold. redirect_valid is ignored; the stalled ID stage re-asserts it once released. fetch_cnt holds.
- Redirect to an illegal target is accepted. The fault is raised when that PC is fetched, not earlier.
- fetch_cnt increments on every edge where IF/ID loads with if_id_valid=1. It saturates at 32'hFFFF_FFFF.
- After a fault, fetching continues (pc+4 or redirect). Only the sticky flag records it. No internal halt.

Decomposition:
- Shared package mips_pkg: RESET_PC default, NOP word 32'h0000_0000, IM_ADDRBITS default.
- One sub-module, pc_range_check: combinational legal/illegal decision. The same check is reused by the data-memory address path.
- Everything else is inline.

Test Plan:
- Reset, then 3 free-running cycles with im_rdata=pc-derived pattern -> im_addr 0x3000,0x3004,0x3008; IF/ID pc 0x3000,0x3004 with matching instr; if_id_pc8=0x3008 for pc 0x3000; fetch_cnt=2.
- Redirect_valid=1, redirect_pc=0x3100 while pc=0x3010 -> IF/ID latches 0x3010 (delay slot, valid=1); next im_addr=0x3100.
- Stall=1 for 3 cycles with redirect_valid=1 asserted throughout at pc=0x3020 -> pc and IF/ID unchanged, fetch_cnt unchanged. Release stall with redirect_valid=1, redirect_pc=0x3200 -> next pc=0x3200.
- Redirect to 0x3002 (misaligned) and separately to 0x7000 (>=0x7000 limit) -> following edge: if_id_fault=1, if_id_valid=0, if_id_instr=0, fault_sticky=1. fault_sticky persists after later legal fetches.
- Boundary: pc=0x6FFC -> legal fetch (valid=1); next pc=0x7000 -> fault. Redirect to 0x2FFC -> fault.
- Assert reset during stall with redirect_valid=1 -> all outputs at reset values next edge, im_addr=0x3000; fetch_cnt preloaded via force to 0xFFFFFFFF stays saturated on a valid fetch.
